// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, divider state encoding and
// divide-by-zero result constants.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  // Divider control states; FIXUP is only reached in the signed build.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  // Divide-by-zero quotient is every bit set to this value (all ones).
  localparam logic DIV_ZERO_QUOT_FILL = 1'b1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract the
// divisor and keep the difference when it is non-negative.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] r_shift_s;
  logic [WIDTH:0] trial_s;

  // R < divisor on entry, so the trial difference always fits in WIDTH+1 signed bits.
  always_comb begin
    r_shift_s = {r_in, q_in[WIDTH-1]};
    trial_s   = r_shift_s - {1'b0, divisor};
    if (trial_s[WIDTH] == 1'b0) begin
      r_out = trial_s[WIDTH-1:0];
      q_out = {q_in[WIDTH-2:0], 1'b1};
    end else begin
      r_out = r_shift_s[WIDTH-1:0];
      q_out = {q_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, start/busy/done
// handshake. Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands
// (adds a one-cycle FIXUP state for sign correction).
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  div_state_t       state_r, state_nxt_s;
  logic             accept_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] div_r, rem_r, quo_r;
  logic [WIDTH-1:0] step_r_s, step_q_s;
  logic [WIDTH-1:0] dvd_mag_s, dvs_mag_s, dbz_quot_s;
  logic [WIDTH-1:0] quotient_r, remainder_r;
  logic             busy_r, done_r, dbz_r;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in    (rem_r),
    .q_in    (quo_r),
    .divisor (div_r),
    .r_out   (step_r_s),
    .q_out   (step_q_s)
  );

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q_r, neg_r_r;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  // Operand magnitudes and the sign-dependent divide-by-zero quotient.
  always_comb begin
    if (dividend[WIDTH-1] == 1'b1) begin
      dvd_mag_s  = neg_w(dividend);
      dbz_quot_s = ONE_W;
    end else begin
      dvd_mag_s  = dividend;
      dbz_quot_s = {WIDTH{DIV_ZERO_QUOT_FILL}};
    end
    if (divisor[WIDTH-1] == 1'b1) begin
      dvs_mag_s = neg_w(divisor);
    end else begin
      dvs_mag_s = divisor;
    end
  end
`else
  assign dvd_mag_s  = dividend;
  assign dvs_mag_s  = divisor;
  assign dbz_quot_s = {WIDTH{DIV_ZERO_QUOT_FILL}};
`endif

  // Next-state logic; start is only honoured in IDLE or DONE.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          accept_s = 1'b1;
          if (divisor == {WIDTH{1'b0}}) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          state_nxt_s = FIXUP;
`else
          state_nxt_s = DONE;
`endif
        end else begin
          state_nxt_s = RUN;
        end
      end
      FIXUP:   state_nxt_s = DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, handshake flags, working registers and held results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      div_r       <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      quo_r       <= {WIDTH{1'b0}};
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN) || (state_nxt_s == FIXUP);
      done_r  <= (state_nxt_s == DONE);
      if (accept_s) begin
        if (divisor == {WIDTH{1'b0}}) begin
          quotient_r  <= dbz_quot_s;
          remainder_r <= dividend;
          dbz_r       <= 1'b1;
          cnt_r       <= {CNT_W{1'b0}};
        end else begin
          div_r <= dvs_mag_s;
          rem_r <= {WIDTH{1'b0}};
          quo_r <= dvd_mag_s;
          cnt_r <= CNT_LAST;
          dbz_r <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
          neg_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r_r <= dividend[WIDTH-1];
`endif
        end
      end else if (state_r == RUN) begin
        rem_r <= step_r_s;
        quo_r <= step_q_s;
        if (cnt_r == {CNT_W{1'b0}}) begin
          quotient_r  <= step_q_s;
          remainder_r <= step_r_s;
        end else begin
          cnt_r <= cnt_r - CNT_ONE;
        end
`ifdef SEQ_DIVIDER_SIGNED_EN
      end else if (state_r == FIXUP) begin
        // Truncation toward zero: quotient sign from both operands, remainder from dividend.
        quotient_r  <= neg_q_r ? neg_w(quotient_r) : quotient_r;
        remainder_r <= neg_r_r ? neg_w(remainder_r) : remainder_r;
`endif
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider. Cycle numbering: the cycle in
// which start is presented is cycle 0; the accepting edge ends it.
module tb_seq_divider;

  localparam int W = 16;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;
  int lat;
  int busy_n;
  int done_n;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one cycle; returns at the negedge of cycle 1.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; lat0 is the cycle number currently being sampled.
  task automatic wait_done(input int lat0, output int l, output int b);
    l = lat0; b = 0;
    while (!done && l < 60) begin
      if (busy) b++;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] q,
                              input logic [W-1:0] r, input logic z);
    check({tag, "_q"}, 32'(quotient), 32'(q));
    check({tag, "_r"}, 32'(remainder), 32'(r));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(z));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = 16'd0; divisor = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_result("rst", 16'd0, 16'd0, 1'b0);
    rst = 1'b0;

    // 100 / 7 = 14 r 2, with latency and busy-length checks
    launch(16'd100, 16'd7);
    wait_done(1, lat, busy_n);
    check("lat_100_7", 32'(lat), 32'(LAT));
    check("busy_len", 32'(busy_n), 32'(LAT - 1));
    check("busy_at_done", 32'(busy), 32'd0);
    check_result("d100_7", 16'd14, 16'd2, 1'b0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("hold_q", 32'(quotient), 32'd14);

    // All-ones dividend, then dividend < divisor, then zero dividend
    launch(16'hFFFF, 16'h0001);
    wait_done(1, lat, busy_n);
    check_result("dffff_1", 16'hFFFF, 16'h0000, 1'b0);
    launch(16'd5, 16'd9);
    wait_done(1, lat, busy_n);
    check_result("d5_9", 16'd0, 16'd5, 1'b0);
    launch(16'd0, 16'd5);
    wait_done(1, lat, busy_n);
    check_result("d0_5", 16'd0, 16'd0, 1'b0);

    // Divide by zero, then a normal division clears the flag
    launch(16'd1234, 16'd0);
    wait_done(1, lat, busy_n);
    check("lat_dbz", 32'(lat), 32'd1);
    check_result("d1234_0", 16'hFFFF, 16'd1234, 1'b1);
    launch(16'd10, 16'd3);
    check("dbz_clear_at_accept", 32'(div_by_zero), 32'd0);
    wait_done(1, lat, busy_n);
    check_result("d10_3", 16'd3, 16'd1, 1'b0);

    // Start while busy is ignored; start in the DONE cycle is accepted
    launch(16'd100, 16'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, lat, busy_n);
    check("lat_ignore", 32'(lat), 32'(LAT));
    check_result("ignore_busy", 16'd14, 16'd2, 1'b0);
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done_start", 32'(busy), 32'd1);
    wait_done(1, lat, busy_n);
    check("lat_b2b", 32'(lat), 32'(LAT));
    check_result("d50_5", 16'd10, 16'd0, 1'b0);

    // Reset mid-operation aborts with no done pulse
    launch(16'd1000, 16'd3);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check_result("abort", 16'd0, 16'd0, 1'b0);
    done_n = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("abort_no_done", 32'(done_n), 32'd0);
    launch(16'd9, 16'd3);
    wait_done(1, lat, busy_n);
    check_result("d9_3", 16'd3, 16'd0, 1'b0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    // Signed: truncation toward zero and most-negative / -1 wrap
    launch(16'hFFF9, 16'd2);
    wait_done(1, lat, busy_n);
    check("lat_signed", 32'(lat), 32'd18);
    check_result("sm7_2", 16'hFFFD, 16'hFFFF, 1'b0);
    launch(16'd7, 16'hFFFE);
    wait_done(1, lat, busy_n);
    check_result("s7_m2", 16'hFFFD, 16'd1, 1'b0);
    launch(16'h8000, 16'hFFFF);
    wait_done(1, lat, busy_n);
    check_result("smin_m1", 16'h8000, 16'd0, 1'b0);
    launch(16'hFFF9, 16'd0);
    wait_done(1, lat, busy_n);
    check_result("sm7_0", 16'd1, 16'hFFF9, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
